mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_byte_array.sv | 43 ++++
 rtl/mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared sizes, memory map and FSM state encoding for the
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int ADDRESS_SIZE = 11;
    localparam int WORD_SIZE    = 64;

    localparam logic [ADDRESS_SIZE-1:0] PROGRAM_MEM_START = 'h400;
    localparam logic [ADDRESS_SIZE-1:0] DATA_MEM_START    = 'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
// Module      : mem_byte_array
// Description : Byte-addressed storage with a big-endian 8-byte word port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDRESS_SIZE = mem_pkg::ADDRESS_SIZE,
    parameter int WORD_SIZE    = mem_pkg::WORD_SIZE
) (
    input  logic                    clk,
    input  logic                    i_writeEn,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0]    i_wdata,
    output logic [WORD_SIZE-1:0]    o_rdata
);

    localparam int c_BYTES = WORD_SIZE / 8;

    // Not reset, so preloaded contents survive a reset of the responder.
    logic [7:0] ram_memory [0:(2**ADDRESS_SIZE)-1];

    // Byte addresses wrap here; the caller masks out-of-range accesses.
    for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_readByte
        logic [ADDRESS_SIZE-1:0] w_byteAddr;
        assign w_byteAddr = i_addr + ADDRESS_SIZE'(gi);
        assign o_rdata[WORD_SIZE-1-8*gi -: 8] = ram_memory[w_byteAddr];
    end

    always_ff @(posedge clk) begin
        if (i_writeEn) begin
            for (int i = 0; i < c_BYTES; i++) begin
                ram_memory[i_addr + ADDRESS_SIZE'(i)] <= i_wdata[WORD_SIZE-1-8*i -: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with fixed access latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDRESS_SIZE = mem_pkg::ADDRESS_SIZE,
    parameter int WORD_SIZE    = mem_pkg::WORD_SIZE,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WORD_SIZE-1:0]    resp_rdata,
    output logic                    resp_err
);

    localparam logic [ADDRESS_SIZE-1:0] c_MAX_ADDR = ADDRESS_SIZE'((2**ADDRESS_SIZE) - 8);
    localparam logic [3:0]              c_LATENCY  = 4'(LATENCY);

    state_t                  r_state, w_nextState;
    logic [3:0]              r_counter, w_nextCounter;
    logic                    r_write;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WORD_SIZE-1:0]    r_rdata;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_inRange;
    logic                    w_memWrite;
    logic [WORD_SIZE-1:0]    w_memRdata;

    // rst_n gates req_ready so it reads 0 while reset is held.
    assign req_ready  = rst_n && (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_inRange  = (r_addr <= c_MAX_ADDR);
    assign w_memWrite = w_access && r_write && w_inRange;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_comb begin
        w_nextState   = r_state;
        w_nextCounter = r_counter;
        w_access      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState   = WAIT;
                    w_nextCounter = c_LATENCY;
                end
            end
            WAIT: begin
                if (r_counter == 4'd0) begin
                    w_access    = 1'b1;
                    w_nextState = RESP;
                end else begin
                    w_nextCounter = r_counter - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_counter <= 4'd0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_counter <= w_nextCounter;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_rdata <= (r_write || !w_inRange) ? '0 : w_memRdata;
                r_err   <= !w_inRange;
            end
        end
    end

    mem_byte_array #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .WORD_SIZE    (WORD_SIZE)
    ) u_mem (
        .clk       (clk),
        .i_writeEn (w_memWrite),
        .i_addr    (r_addr),
        .i_wdata   (r_wdata),
        .o_rdata   (w_memRdata)
    );

endmodule

`default_nettype wire
